// File: rtl/norm_result_serializer_pkg.sv
// Shared types and sizing helpers for norm_result_serializer.
package norm_result_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned IDX_W     = 2;

  // Bits needed to hold values 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/vector_fifo.sv
// Synchronous FIFO of whole vectors.
// Ports: push/din write, pop/dout read (dout shows the head), full/empty/count status.
// A push while full is accepted only when a pop happens in the same cycle.
module vector_fifo #(
  parameter int unsigned WIDTH = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/norm_result_serializer.sv
// Captures the four divider quotients as one vector, buffers vectors and
// streams them one component per beat (A..D) over valid/ready.
// Ports: issue_i/credit_ok launch flow control; in_valid_*/in_q_* lane inputs;
// o_valid/o_ready/o_data/o_idx/o_last output stream; err_* sticky error flags.
module norm_result_serializer
  import norm_result_serializer_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned INSTANCE_ID  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_i,
  output logic                 credit_ok,
  input  logic                 in_valid_A,
  input  logic                 in_valid_B,
  input  logic                 in_valid_C,
  input  logic                 in_valid_D,
  input  logic [DATAWIDTH:0]   in_q_A,
  input  logic [DATAWIDTH:0]   in_q_B,
  input  logic [DATAWIDTH:0]   in_q_C,
  input  logic [DATAWIDTH:0]   in_q_D,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [DATAWIDTH:0]   o_data,
  output logic [1:0]           o_idx,
  output logic                 o_last,
  output logic                 err_overflow,
  output logic                 err_misalign
);

  localparam int unsigned QW = DATAWIDTH + 1;
  localparam int unsigned EW = NUM_LANES * QW;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = cnt_width(MAX_INFLIGHT + FIFO_DEPTH);
  localparam int unsigned SW = ((IW > CW) ? IW : CW) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  logic            unused_id;
  logic            all_valid;
  logic            misalign;
  logic [EW-1:0]   fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            pop_final;
  logic [QW-1:0]   head_lane [NUM_LANES];
  logic [IW-1:0]   inflight;

  state_t          state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]   hold_q;

  assign unused_id = ^INSTANCE_ID;

  assign all_valid = in_valid_A & in_valid_B & in_valid_C & in_valid_D;
  assign misalign  = (in_valid_A | in_valid_B | in_valid_C | in_valid_D) && !all_valid;

  vector_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (all_valid),
    .din   ({in_q_A, in_q_B, in_q_C, in_q_D}),
    .pop   (pop_final),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Lane A sits in the most significant slice of an entry.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      head_lane[i] = fifo_dout[(NUM_LANES - 1 - i) * QW +: QW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else if (issue_i && !all_valid) begin
      inflight <= inflight + IW'(1);
    end else if (!issue_i && all_valid && inflight != '0) begin
      inflight <= inflight - IW'(1);
    end
  end

  assign credit_ok = (SW'(inflight) + SW'(fifo_count)) < SW'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (all_valid && fifo_full && !pop_final) err_overflow <= 1'b1;
      if (misalign)                             err_misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (o_valid && o_ready) hold_q <= o_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_final = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (o_ready) begin
          if (cnt_q == LAST_IDX) begin
            pop_final = 1'b1;
            cnt_d     = '0;
            // A same-cycle capture keeps the stream going without an IDLE gap.
            state_d   = (fifo_count > CW'(1) || all_valid) ? SEND : IDLE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registers only; the held copy covers IDLE.
  always_comb begin
    o_valid = (state_q == SEND);
    o_idx   = cnt_q;
    o_last  = (state_q == SEND) && (cnt_q == LAST_IDX);
    o_data  = (state_q == SEND) ? head_lane[cnt_q] : hold_q;
  end

endmodule
